// File: rtl/dmem_ctrl_if.sv
// Data-bus handshake between the memory-stage controller (master) and the
// variable-latency data memory (slave): request/grant, then read-data valid.
interface dmem_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory controller: stalls the pipeline while a word access
// runs over the request/grant/rvalid bus. DMEM_WBUF_EN adds a posted write buffer.
module dmem_ctrl #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [AW-1:0] addrM,
  input  logic [DW-1:0] wdataM,
  output logic [DW-1:0] readdataM,
  output logic          stallM,
  output logic          adelM,
  output logic          adesM,
  output logic          buserrM,
  dmem_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_R  = 3'd2,
    DONE    = 3'd3,
    WB_REQ  = 3'd4,
    WB_DONE = 3'd5
  } state_t;

  state_t        state_reg;
  logic [7:0]    waitCnt_reg;
  logic          memReq_reg;
  logic          memWe_reg;
  logic [AW-1:0] memAddr_reg;
  logic [DW-1:0] memWdata_reg;
  logic [DW-1:0] readData_reg;
  logic          busErrPulse_reg;

  logic          access;
  logic          aligned;
  logic          isWrite;
  logic          postWrite;
  logic          limitHit;
  logic [AW-1:0] wordAddr;

  assign access   = memreadM | memwriteM;
  assign isWrite  = memwriteM;
  assign aligned  = (addrM[1:0] == 2'b00);
  assign limitHit = (waitCnt_reg == 8'(WAIT_LIMIT - 1));

  // Bus addresses are always word addresses; the byte offset never leaves the block.
  for (genvar gi = 0; gi < AW; gi++) begin : g_align
    if (gi < 2) begin : g_lo
      assign wordAddr[gi] = 1'b0;
    end else begin : g_hi
      assign wordAddr[gi] = addrM[gi];
    end
  end

`ifdef DMEM_WBUF_EN
  logic wbErr_reg;
  assign postWrite = isWrite;
  assign buserrM   = busErrPulse_reg | wbErr_reg;
`else
  assign postWrite = 1'b0;
  assign buserrM   = busErrPulse_reg;
`endif

  assign bus.mem_req   = memReq_reg;
  assign bus.mem_we    = memWe_reg;
  assign bus.mem_addr  = memAddr_reg;
  assign bus.mem_wdata = memWdata_reg;
  assign readdataM     = readData_reg;

  // Alignment faults are only reported for a fresh access seen in IDLE.
  assign adelM = (state_reg == IDLE) && memreadM && !memwriteM && !aligned;
  assign adesM = (state_reg == IDLE) && memwriteM && !aligned;

  always_comb begin
    stallM = 1'b0;
    case (state_reg)
      IDLE:            stallM = access && aligned && !postWrite;
      REQ, WAIT_R:     stallM = 1'b1;
      WB_REQ, WB_DONE: stallM = access;
      default:         stallM = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      waitCnt_reg     <= '0;
      memReq_reg      <= 1'b0;
      memWe_reg       <= 1'b0;
      memAddr_reg     <= '0;
      memWdata_reg    <= '0;
      readData_reg    <= '0;
      busErrPulse_reg <= 1'b0;
`ifdef DMEM_WBUF_EN
      wbErr_reg       <= 1'b0;
`endif
    end else begin
      busErrPulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (access && aligned) begin
            memReq_reg   <= 1'b1;
            memWe_reg    <= isWrite;
            memAddr_reg  <= wordAddr;
            memWdata_reg <= wdataM;
            waitCnt_reg  <= '0;
            state_reg    <= postWrite ? WB_REQ : REQ;
          end
        end

        REQ: begin
          waitCnt_reg <= waitCnt_reg + 8'd1;
          if (bus.mem_gnt) begin
            memReq_reg <= 1'b0;
            state_reg  <= memWe_reg ? DONE : WAIT_R;
          end else if (limitHit) begin
            memReq_reg      <= 1'b0;
            busErrPulse_reg <= 1'b1;
            state_reg       <= DONE;
            if (!memWe_reg) begin
              readData_reg <= '0;
            end
          end
        end

        WAIT_R: begin
          waitCnt_reg <= waitCnt_reg + 8'd1;
          if (bus.mem_rvalid) begin
            readData_reg <= bus.mem_rdata;
            state_reg    <= DONE;
          end else if (limitHit) begin
            readData_reg    <= '0;
            busErrPulse_reg <= 1'b1;
            state_reg       <= DONE;
          end
        end

        // The pipeline advances on this edge, so the held access is never reissued.
        DONE: state_reg <= IDLE;

`ifdef DMEM_WBUF_EN
        WB_REQ: begin
          waitCnt_reg <= waitCnt_reg + 8'd1;
          if (bus.mem_gnt) begin
            memReq_reg <= 1'b0;
            state_reg  <= WB_DONE;
          end else if (limitHit) begin
            memReq_reg <= 1'b0;
            wbErr_reg  <= 1'b1;
            state_reg  <= WB_DONE;
          end
        end

        WB_DONE: state_reg <= IDLE;
`endif

        default: begin
          memReq_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule
